vector_add_axis: RTL and testbench

Parametrised AXI-Stream vector adder: each input beat carries two N-element signed vectors A and B; each output beat carries their element-wise sum S. Unlike the single-beat-in-flight two-element wrapper it succeeds, it has a pipelined adder of configurable latency and a credit-controlled output FIFO, so it sustains one beat per cycle under back-pressure. It sits between upstream stream sources and downstream linear-algebra stages in the Layer0 datapath.

---
 rtl/vector_add_pkg.sv | 40 ++++
 rtl/sync_fifo_fwft.sv | 70 +++++++
 rtl/vector_add_axis.sv | 130 +++++++++++++
 tb/tb_vector_add_axis.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_add_pkg
// Description : Shared helpers for the vector adder: output element width,
//               element bit-offset lookup for MSB-first packing, and signed
//               saturation. VECADD_SAT_EN selects saturating output width.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_add_pkg;

    // Output element width: full-precision sum, or clamped back to W bits.
    function automatic int out_width(input int w);
`ifdef VECADD_SAT_EN
        return w;
`else
        return w + 1;
`endif
    endfunction

    // Lowest bit of element i in an n-element, w-bit-per-element vector whose
    // element 0 occupies the most significant bits.
    function automatic int elem_lo(input int n, input int w, input int i);
        return (n - 1 - i) * w;
    endfunction

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic longint sat_signed(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               presented on dout while not empty; when empty, dout holds the
//               last word read (zero after reset). A write becomes visible the
//               cycle after it is made.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] hold;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign wr_ok = wr_en & (count != FULL);
    assign rd_ok = rd_en & ~empty;
    assign dout  = empty ? hold : mem[rd_ptr];

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the last-read holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_add_axis.sv
`default_nettype none
// ============================================================================
// Module      : vector_add_axis
// Description : AXI-Stream element-wise adder of two N-element signed vectors.
//               LAT-stage adder pipeline feeding a FWFT output FIFO; a credit
//               counter admits a beat only when FIFO space is guaranteed, so
//               the pipeline never stalls. Define VECADD_SAT_EN to saturate
//               each sum to W bits in the final pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_add_axis
    import vector_add_pkg::*;
#(
    parameter int  N     = 2,
    parameter int  W     = 10,
    parameter int  LAT   = 2,
    parameter int  DEPTH = 4,
    localparam int OW    = out_width(W)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [2*N*W-1:0]  s_axis_data,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    output logic [N*OW-1:0]   m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready
);

    localparam int            SW      = W + 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    logic [CW-1:0]   cnt;
    logic            in_hs;
    logic            out_hs;
    logic [N*SW-1:0] sum_c;
    logic [N*SW-1:0] stage_in  [LAT];
    logic [N*SW-1:0] final_in;
    logic [N*SW-1:0] pipe_data [LAT];
    logic [LAT-1:0]  pipe_valid;
    logic [N*OW-1:0] fifo_din;
    logic            fifo_rd;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Ready depends only on registered credit state, never on s_axis_valid.
    assign s_axis_ready = aresetn & enable & (cnt < CREDITS);
    assign in_hs        = s_axis_valid & s_axis_ready;
    assign m_axis_valid = (fifo_count != '0);
    assign out_hs       = m_axis_valid & m_axis_ready;
    assign fifo_rd      = m_axis_ready & ~fifo_empty;

    // Credit counter: beats held in the pipeline plus beats queued in the FIFO.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            cnt <= '0;
        else if (in_hs && !out_hs)
            cnt <= cnt + 1'b1;
        else if (!in_hs && out_hs)
            cnt <= cnt - 1'b1;
    end

    // Per-element sign-extended add, final-stage clamp and output packing.
    for (genvar i = 0; i < N; i++) begin : g_elem
        logic signed [W-1:0]  a;
        logic signed [W-1:0]  b;
        logic signed [SW-1:0] sat_in;
        logic signed [SW-1:0] sat_out;

        assign a = s_axis_data[elem_lo(2*N, W, i) +: W];
        assign b = s_axis_data[elem_lo(2*N, W, N+i) +: W];
        assign sum_c[elem_lo(N, SW, i) +: SW] = {a[W-1], a} + {b[W-1], b};

        assign sat_in = stage_in[LAT-1][elem_lo(N, SW, i) +: SW];
`ifdef VECADD_SAT_EN
        assign sat_out = SW'(sat_signed(64'(sat_in), W));
`else
        assign sat_out = sat_in;
`endif
        assign final_in[elem_lo(N, SW, i) +: SW] = sat_out;

        // Clamped sums already fit OW bits, so dropping the top bit is exact.
        assign fifo_din[elem_lo(N, OW, i) +: OW] = pipe_data[LAT-1][elem_lo(N, SW, i) +: OW];
    end

    // Input of each pipeline stage: fresh sums for stage 0, else previous stage.
    for (genvar k = 0; k < LAT; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = sum_c;
        end else begin : g_next
            assign stage_in[k] = pipe_data[k-1];
        end
    end

    // Pipeline data advances every cycle; the last stage takes the clamped value.
    always_ff @(posedge aclk) begin
        for (int k = 0; k < LAT - 1; k++)
            pipe_data[k] <= stage_in[k];
        pipe_data[LAT-1] <= final_in;
    end

    // Pipeline valid shift register, cleared on reset to drop in-flight beats.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= in_hs;
            for (int k = 1; k < LAT; k++)
                pipe_valid[k] <= pipe_valid[k-1];
        end
    end

    sync_fifo_fwft #(
        .WIDTH (N*OW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .wr_en (pipe_valid[LAT-1]),
        .din   (fifo_din),
        .rd_en (fifo_rd),
        .dout  (m_axis_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_vector_add_axis.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_add_axis
// Description : Directed self-checking bench for vector_add_axis (N=2, W=10,
//               LAT=2, DEPTH=4). Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_add_axis;

    localparam int N     = 2;
    localparam int W     = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`ifdef VECADD_SAT_EN
    localparam int OW    = W;
`else
    localparam int OW    = W + 1;
`endif

    logic              aclk         = 1'b0;
    logic              aresetn      = 1'b0;
    logic              enable       = 1'b0;
    logic [2*N*W-1:0]  s_axis_data  = '0;
    logic              s_axis_valid = 1'b0;
    logic              s_axis_ready;
    logic [N*OW-1:0]   m_axis_data;
    logic              m_axis_valid;
    logic              m_axis_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    vector_add_axis #(
        .N     (N),
        .W     (W),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready)
    );

    function automatic logic [2*N*W-1:0] pack_in(input int a0, input int a1, input int b0, input int b1);
        logic [W-1:0] x0, x1, y0, y1;
        x0 = W'(a0); x1 = W'(a1); y0 = W'(b0); y1 = W'(b1);
        return {x0, x1, y0, y1};
    endfunction

    function automatic int out_s(input logic [N*OW-1:0] d, input int i);
        logic signed [OW-1:0] e;
        e = d[(N-1-i)*OW +: OW];
        return int'(e);
    endfunction

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b1; s_axis_valid = 1'b0; m_axis_ready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (s_axis_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", s_axis_ready); end
        checks++;
        if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", m_axis_valid); end
        checks++;
        if (m_axis_data !== '0) begin errors++; $display("FAIL reset_mdata: got %h want 0", m_axis_data); end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", s_axis_ready); end
    endtask

    task automatic test_single();
        m_axis_ready = 1'b1;
        s_axis_data  = pack_in(3, -5, 4, 7);
        s_axis_valid = 1'b1;
        checks++;
        if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", s_axis_ready); end
        @(negedge aclk);
        s_axis_valid = 1'b0;
        checks++;
        if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL single_early1: got %b want 0", m_axis_valid); end
        @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL single_early2: got %b want 0", m_axis_valid); end
        @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b1 || out_s(m_axis_data, 0) != 7 || out_s(m_axis_data, 1) != 2) begin
            errors++;
            $display("FAIL single_sum: got v=%b S=(%0d,%0d) want v=1 S=(7,2)", m_axis_valid, out_s(m_axis_data, 0), out_s(m_axis_data, 1));
        end
        @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b0 || out_s(m_axis_data, 0) != 7 || out_s(m_axis_data, 1) != 2) begin
            errors++;
            $display("FAIL single_hold: got v=%b S=(%0d,%0d) want v=0 S=(7,2)", m_axis_valid, out_s(m_axis_data, 0), out_s(m_axis_data, 1));
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        int first = -1;
        int last = -1;
        m_axis_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (m_axis_valid === 1'b1) begin
                checks++;
                if (rx >= 8) begin
                    errors++; $display("FAIL b2b_extra: got beat %0d want none", rx);
                end else if (out_s(m_axis_data, 0) != 11*rx + 1 || out_s(m_axis_data, 1) != 50 - 4*rx) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got (%0d,%0d) want (%0d,%0d)", rx, out_s(m_axis_data, 0), out_s(m_axis_data, 1), 11*rx + 1, 50 - 4*rx);
                end
                if (first < 0) first = c;
                last = c;
                rx++;
            end
            if (tx < 8) begin
                s_axis_data  = pack_in(10*tx + 1, -3*tx, tx, 50 - tx);
                s_axis_valid = 1'b1;
                checks++;
                if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", tx, s_axis_ready); end
                tx++;
            end else begin
                s_axis_valid = 1'b0;
            end
            @(negedge aclk);
        end
        checks++;
        if (rx != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", rx); end
        checks++;
        if (last - first != 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 7", last - first); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int rx = 0;
        m_axis_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_axis_data  = pack_in(-100 + acc, 200, acc*acc, -acc);
            s_axis_valid = 1'b1;
            if (s_axis_ready === 1'b1) acc++;
            @(negedge aclk);
        end
        s_axis_valid = 1'b0;
        checks++;
        if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        checks++;
        if (s_axis_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", s_axis_ready); end
        @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b1 || out_s(m_axis_data, 0) != -100 || out_s(m_axis_data, 1) != 200) begin
            errors++;
            $display("FAIL bp_stable: got v=%b S=(%0d,%0d) want v=1 S=(-100,200)", m_axis_valid, out_s(m_axis_data, 0), out_s(m_axis_data, 1));
        end
        m_axis_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_axis_valid === 1'b1) begin
                checks++;
                if (rx >= 4) begin
                    errors++; $display("FAIL bp_extra: got beat %0d want none", rx);
                end else if (out_s(m_axis_data, 0) != -100 + rx + rx*rx || out_s(m_axis_data, 1) != 200 - rx) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got (%0d,%0d) want (%0d,%0d)", rx, out_s(m_axis_data, 0), out_s(m_axis_data, 1), -100 + rx + rx*rx, 200 - rx);
                end
                rx++;
            end
            @(negedge aclk);
        end
        checks++;
        if (rx != 4) begin errors++; $display("FAIL bp_drained: got %0d want 4", rx); end
        checks++;
        if (s_axis_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", s_axis_ready); end
    endtask

    task automatic test_saturation();
        int e0 [2];
        int e1 [2];
        int rx = 0;
`ifdef VECADD_SAT_EN
        e0 = '{511, -512};
        e1 = '{-512, 0};
`else
        e0 = '{512, -513};
        e1 = '{-513, 0};
`endif
        m_axis_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_axis_valid === 1'b1) begin
                checks++;
                if (rx == 0) begin
                    if (out_s(m_axis_data, 0) != e0[0] || out_s(m_axis_data, 1) != e0[1]) begin
                        errors++;
                        $display("FAIL sat_beat0: got (%0d,%0d) want (%0d,%0d)", out_s(m_axis_data, 0), out_s(m_axis_data, 1), e0[0], e0[1]);
                    end
                end else if (rx == 1) begin
                    if (out_s(m_axis_data, 0) != e1[0] || out_s(m_axis_data, 1) != e1[1]) begin
                        errors++;
                        $display("FAIL sat_beat1: got (%0d,%0d) want (%0d,%0d)", out_s(m_axis_data, 0), out_s(m_axis_data, 1), e1[0], e1[1]);
                    end
                end else begin
                    errors++; $display("FAIL sat_extra: got beat %0d want none", rx);
                end
                rx++;
            end
            if (c == 0) begin
                s_axis_data = pack_in(511, -512, 1, -1); s_axis_valid = 1'b1;
            end else if (c == 1) begin
                s_axis_data = pack_in(-512, 100, -1, -100); s_axis_valid = 1'b1;
            end else begin
                s_axis_valid = 1'b0;
            end
            @(negedge aclk);
        end
        checks++;
        if (rx != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", rx); end
    endtask

    task automatic test_enable();
        int rx = 0;
        m_axis_ready = 1'b1;
        enable = 1'b1;
        s_axis_data = pack_in(20, 30, 1, 2); s_axis_valid = 1'b1;
        @(negedge aclk);
        s_axis_data = pack_in(-20, -30, -1, -2);
        @(negedge aclk);
        enable = 1'b0;
        s_axis_data = pack_in(99, 99, 99, 99);
        #1;
        checks++;
        if (s_axis_ready !== 1'b0) begin errors++; $display("FAIL en_ready_low: got %b want 0", s_axis_ready); end
        @(negedge aclk);
        for (int c = 0; c < 8; c++) begin
            if (m_axis_valid === 1'b1) begin
                checks++;
                if (rx == 0 && (out_s(m_axis_data, 0) != 21 || out_s(m_axis_data, 1) != 32)) begin
                    errors++; $display("FAIL en_beat0: got (%0d,%0d) want (21,32)", out_s(m_axis_data, 0), out_s(m_axis_data, 1));
                end else if (rx == 1 && (out_s(m_axis_data, 0) != -21 || out_s(m_axis_data, 1) != -32)) begin
                    errors++; $display("FAIL en_beat1: got (%0d,%0d) want (-21,-32)", out_s(m_axis_data, 0), out_s(m_axis_data, 1));
                end else if (rx > 1) begin
                    errors++; $display("FAIL en_extra: got beat %0d want none", rx);
                end
                rx++;
            end
            @(negedge aclk);
        end
        checks++;
        if (rx != 2) begin errors++; $display("FAIL en_drained: got %0d want 2", rx); end
        checks++;
        if (s_axis_ready !== 1'b0) begin errors++; $display("FAIL en_ready_still_low: got %b want 0", s_axis_ready); end
        s_axis_valid = 1'b0;
        enable = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int acc = 0;
        m_axis_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_axis_data = pack_in(c + 1, c + 2, c + 3, c + 4); s_axis_valid = 1'b1;
            @(negedge aclk);
        end
        s_axis_valid = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_queued: got %b want 1", m_axis_valid); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++;
        if (m_axis_valid !== 1'b0 || m_axis_data !== '0 || s_axis_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cleared: got v=%b d=%h r=%b want v=0 d=0 r=0", m_axis_valid, m_axis_data, s_axis_ready);
        end
        aresetn = 1'b1;
        m_axis_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_axis_valid === 1'b1) seen++;
            @(negedge aclk);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d outputs want 0", seen); end
        m_axis_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            s_axis_data = pack_in(5, 5, 5, 5); s_axis_valid = 1'b1;
            if (s_axis_ready === 1'b1) acc++;
            @(negedge aclk);
        end
        s_axis_valid = 1'b0;
        checks++;
        if (acc != DEPTH) begin errors++; $display("FAIL rst_mid_credits: got %0d accepted want %0d", acc, DEPTH); end
        m_axis_ready = 1'b1;
        repeat (8) @(negedge aclk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
